// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector MAC array: FSM encoding,
// accumulator sizing and the output conversion classifier.
package matvec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // Outcome of narrowing one accumulator to the output element width.
   typedef enum logic [1:0] {
      CONV_PASS    = 2'd0,
      CONV_CLIP_HI = 2'd1,
      CONV_CLIP_LO = 2'd2,
      CONV_LOSS    = 2'd3
   } conv_e;

   // Room for N full-scale signed products without overflow.
   function automatic int acc_width(input int n, input int width);
      return 2 * width + $clog2(n);
   endfunction

   function automatic conv_e convert_elem(input logic signed [63:0] acc,
                                          input int width,
                                          input logic sat_mode);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      logic signed [63:0] sext;
      conv_e res;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      sext  = (acc <<< (64 - width)) >>> (64 - width);
      res   = CONV_PASS;
      if (sat_mode) begin
         if (acc > max_v) begin
            res = CONV_CLIP_HI;
         end else if (acc < min_v) begin
            res = CONV_CLIP_LO;
         end
      end else if (sext != acc) begin
         res = CONV_LOSS;
      end
      return res;
   endfunction

endpackage

// File: rtl/matvec_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
// sum_next is the running sum including the current product.
module matvec_mac_lane
   import matvec_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ACC_W = acc_width(4, WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [ACC_W-1:0] sum_next
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   acc;

   assign prod     = a * b;
   assign sum_next = acc + {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum_next;
      end
   end

endmodule

// File: rtl/matvec_mac_array.sv
// Matrix-vector multiplier: LANES rows are accumulated in parallel, one
// column per cycle, then converted to WIDTH bits and held until taken.
module matvec_mac_array
   import matvec_pkg::*;
#(
   parameter int N        = 4,
   parameter int WIDTH    = 8,
   parameter int LANES    = 2,
   parameter int SAT_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N*N*WIDTH-1:0]     matrix_a,
   input  logic [N*WIDTH-1:0]       vector_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N*WIDTH-1:0]       vector_c,
   output logic [N-1:0]             sat_flags,
   output state_t                   state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // in_ready depends on state only, and vector_c/sat_flags are stable
   // while out_valid is high until out_ready is seen.

   localparam int ACC_W  = acc_width(N, WIDTH);
   localparam int GROUPS = N / LANES;
   localparam int KW     = $clog2(N);
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
   localparam logic [GW-1:0]    G_LAST = GW'(GROUPS - 1);
   localparam logic [WIDTH-1:0] MAX_V  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                  state;
   logic [N*N*WIDTH-1:0]    a_q;
   logic [N*WIDTH-1:0]      b_q;
   logic [KW-1:0]           k_cnt;
   logic [GW-1:0]           g_cnt;
   logic                    mac_done;
   logic signed [ACC_W-1:0] row_acc  [N];
   logic signed [ACC_W-1:0] lane_sum [LANES];
   logic [N*WIDTH-1:0]      conv_vec;
   logic [N-1:0]            conv_flags;
   conv_e                   cls;
   logic                    accept;
   logic                    mac_en;
   logic                    col_last;
   logic                    lane_clr;

   assign in_ready  = (state == ST_IDLE);
   assign state_dbg = state;
   assign accept    = in_valid && in_ready;
   assign mac_en    = (state == ST_COMPUTE) && !mac_done;
   assign col_last  = (k_cnt == K_LAST);
   // Lanes restart at every row boundary; the finished sum is captured via sum_next.
   assign lane_clr  = accept || (mac_en && col_last);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [WIDTH-1:0] lane_a;
      logic signed [WIDTH-1:0] lane_b;

      always_comb begin
         lane_a = '0;
         lane_b = '0;
         for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
               if ((int'(g_cnt) * LANES + l == r) && (int'(k_cnt) == k)) begin
                  lane_a = a_q[(r*N + k)*WIDTH +: WIDTH];
               end
            end
         end
         for (int k = 0; k < N; k++) begin
            if (int'(k_cnt) == k) begin
               lane_b = b_q[k*WIDTH +: WIDTH];
            end
         end
      end

      matvec_mac_lane #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (lane_clr),
         .en       (mac_en),
         .a        (lane_a),
         .b        (lane_b),
         .sum_next (lane_sum[l])
      );
   end

   always_comb begin
      conv_vec   = '0;
      conv_flags = '0;
      cls        = CONV_PASS;
      for (int r = 0; r < N; r++) begin
         cls = convert_elem({{(64-ACC_W){row_acc[r][ACC_W-1]}}, row_acc[r]},
                            WIDTH, SAT_MODE != 0);
         case (cls)
            CONV_CLIP_HI: conv_vec[r*WIDTH +: WIDTH] = MAX_V;
            CONV_CLIP_LO: conv_vec[r*WIDTH +: WIDTH] = MIN_V;
            default:      conv_vec[r*WIDTH +: WIDTH] = row_acc[r][WIDTH-1:0];
         endcase
         conv_flags[r] = (cls != CONV_PASS);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         vector_c  <= '0;
         sat_flags <= '0;
         a_q       <= '0;
         b_q       <= '0;
         k_cnt     <= '0;
         g_cnt     <= '0;
         mac_done  <= 1'b0;
         for (int r = 0; r < N; r++) row_acc[r] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q      <= matrix_a;
                  b_q      <= vector_b;
                  k_cnt    <= '0;
                  g_cnt    <= '0;
                  mac_done <= 1'b0;
                  for (int r = 0; r < N; r++) row_acc[r] <= '0;
                  state    <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               if (!mac_done) begin
                  if (col_last) begin
                     for (int r = 0; r < N; r++) begin
                        for (int l = 0; l < LANES; l++) begin
                           if (int'(g_cnt) * LANES + l == r) row_acc[r] <= lane_sum[l];
                        end
                     end
                     k_cnt <= '0;
                     if (g_cnt == G_LAST) begin
                        g_cnt    <= '0;
                        mac_done <= 1'b1;
                     end else begin
                        g_cnt <= g_cnt + 1'b1;
                     end
                  end else begin
                     k_cnt <= k_cnt + 1'b1;
                  end
               end else begin
                  // All rows are final; convert once and present the result.
                  vector_c  <= conv_vec;
                  sat_flags <= conv_flags;
                  out_valid <= 1'b1;
                  mac_done  <= 1'b0;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matvec_mac_array.sv
// Directed and randomized checks of matvec_mac_array, instantiated once per
// output conversion mode and driven with identical stimulus.
module tb_matvec_mac_array;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int L  = 2;
   localparam int VW = N * W;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              in_valid  = 1'b0;
   logic              out_ready = 1'b0;
   logic [N*N*W-1:0]  matrix_a  = '0;
   logic [VW-1:0]     vector_b  = '0;

   logic              in_ready_s, out_valid_s, in_ready_t, out_valid_t;
   logic [VW-1:0]     vector_c_s, vector_c_t;
   logic [N-1:0]      sat_flags_s, sat_flags_t;
   matvec_pkg::state_t state_s, state_t_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [VW+N-1:0] exp_q[$];
   logic [VW+N-1:0] exp_t_q[$];

   always #5 clk = ~clk;

   matvec_mac_array #(.N(N), .WIDTH(W), .LANES(L), .SAT_MODE(1)) u_sat (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready_s),
      .matrix_a (matrix_a), .vector_b (vector_b), .out_valid (out_valid_s),
      .out_ready (out_ready), .vector_c (vector_c_s), .sat_flags (sat_flags_s),
      .state_dbg (state_s)
   );

   matvec_mac_array #(.N(N), .WIDTH(W), .LANES(L), .SAT_MODE(0)) u_trn (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready_t),
      .matrix_a (matrix_a), .vector_b (vector_b), .out_valid (out_valid_t),
      .out_ready (out_ready), .vector_c (vector_c_t), .sat_flags (sat_flags_t),
      .state_dbg (state_t_dbg)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid_s && lat < 100);
   endtask

   task automatic run_op(input logic [N*N*W-1:0] a, input logic [VW-1:0] b, output int lat);
      matrix_a = a;
      vector_b = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [VW+N-1:0] model(input logic [N*N*W-1:0] a,
                                             input logic [VW-1:0] b, input bit sat);
      logic [VW-1:0] vec;
      logic [N-1:0]  fl;
      int            s;
      vec = '0;
      fl  = '0;
      for (int r = 0; r < N; r++) begin
         s = 0;
         for (int k = 0; k < N; k++)
            s += int'($signed(a[(r*N + k)*W +: W])) * int'($signed(b[k*W +: W]));
         if (sat && s > 127) begin
            vec[r*W +: W] = 8'h7f;
            fl[r] = 1'b1;
         end else if (sat && s < -128) begin
            vec[r*W +: W] = 8'h80;
            fl[r] = 1'b1;
         end else begin
            vec[r*W +: W] = 8'(s);
            fl[r] = (s > 127) || (s < -128);
         end
      end
      return {fl, vec};
   endfunction

   function automatic logic [N*N*W-1:0] identity_a();
      logic [N*N*W-1:0] a;
      a = '0;
      for (int r = 0; r < N; r++) a[(r*N + r)*W +: W] = 8'd1;
      return a;
   endfunction

   logic [N*N*W-1:0] ra [10];
   logic [VW-1:0]    rb [10];
   logic [N*N*W-1:0] a_tmp;
   logic [VW-1:0]    held_c;
   logic [VW+N-1:0]  e;
   int               lat;
   int               waited;
   int               seen;
   int               stall;
   logic             acc_ok;

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid_s, 0);
      check("rst_vector_c", vector_c_s, 0);
      check("rst_sat_flags", sat_flags_s, 0);
      check("rst_state", state_s, matvec_pkg::ST_IDLE);
      check("rst_out_valid_t", out_valid_t, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready_s, 1);

      // Identity matrix
      run_op(identity_a(), 32'h04030201, lat);
      check("ident_latency", lat, 9);
      check("ident_vec", vector_c_s, 32'h04030201);
      check("ident_flags", sat_flags_s, 0);
      check("ident_vec_t", vector_c_t, 32'h04030201);
      check("ident_flags_t", sat_flags_t, 0);
      release_out();
      check("ident_done_valid", out_valid_s, 0);

      // All 127: sum 64516 clips to 127, truncates to 0x04
      run_op({16{8'h7f}}, {4{8'h7f}}, lat);
      check("pos_latency", lat, 9);
      check("pos_vec_sat", vector_c_s, 32'h7f7f7f7f);
      check("pos_flags_sat", sat_flags_s, 4'hf);
      check("pos_vec_trn", vector_c_t, 32'h04040404);
      check("pos_flags_trn", sat_flags_t, 4'hf);
      release_out();

      // A = -128, B = 127: sum -65024 clips to -128, truncates to 0
      run_op({16{8'h80}}, {4{8'h7f}}, lat);
      check("neg_vec_sat", vector_c_s, 32'h80808080);
      check("neg_flags_sat", sat_flags_s, 4'hf);
      check("neg_vec_trn", vector_c_t, 32'h00000000);
      check("neg_flags_trn", sat_flags_t, 4'hf);
      release_out();

      // A[r][c] = r + c, B = 1: row sums 6, 10, 14, 18; then stall in HOLD
      a_tmp = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) a_tmp[(r*N + c)*W +: W] = 8'(r + c);
      run_op(a_tmp, {4{8'h01}}, lat);
      check("ramp_vec", vector_c_s, 32'h120e0a06);
      check("ramp_flags", sat_flags_s, 0);
      held_c = vector_c_s;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            matrix_a = {16{8'h55}};
            vector_b = {4{8'h33}};
            in_valid = 1'b1;
         end
         tick();
         in_valid = 1'b0;
         check("stall_vec", vector_c_s, 32'h120e0a06);
         check("stall_in_ready", in_ready_s, 0);
         check("stall_out_valid", out_valid_s, 1);
      end
      release_out();
      check("release_valid", out_valid_s, 0);
      check("release_in_ready", in_ready_s, 1);
      check("release_vec_kept", vector_c_s, held_c);
      seen = 0;
      repeat (12) begin
         tick();
         if (out_valid_s) seen++;
      end
      check("stall_pulse_ignored", seen, 0);

      // Reset during COMPUTE cycle 3
      matrix_a = {16{8'h7f}};
      vector_b = {4{8'h7f}};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("mid_state", state_s, matvec_pkg::ST_COMPUTE);
      rst_n = 1'b0;
      tick();
      check("abort_out_valid", out_valid_s, 0);
      check("abort_vector_c", vector_c_s, 0);
      check("abort_in_ready", in_ready_s, 1);
      check("abort_flags", sat_flags_s, 0);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         tick();
         if (out_valid_s) seen++;
      end
      check("abort_no_partial", seen, 0);
      run_op(identity_a(), 32'h04fd02ff, lat);
      check("after_abort_latency", lat, 9);
      check("after_abort_vec", vector_c_s, 32'h04fd02ff);
      check("after_abort_flags", sat_flags_s, 0);
      release_out();

      // Random back-to-back operations with random stalls
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < N*N; j++) ra[i][j*W +: W] = 8'($urandom_range(0, 255));
         for (int j = 0; j < N; j++) rb[i][j*W +: W] = 8'($urandom_range(0, 255));
         exp_q.push_back(model(ra[i], rb[i], 1'b1));
         exp_t_q.push_back(model(ra[i], rb[i], 1'b0));
      end
      tick();
      matrix_a = ra[0];
      vector_b = rb[0];
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         waited = 0;
         acc_ok = 1'b0;
         while (!acc_ok && waited < 50) begin
            acc_ok = in_ready_s;
            tick();
            waited++;
         end
         check("rnd_accept", acc_ok, 1);
         check("rnd_b2b_gap", waited, 1);
         in_valid = 1'b0;
         wait_valid(lat);
         check("rnd_latency", lat, 9);
         stall = $urandom_range(0, 3);
         repeat (stall) tick();
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rnd_vec_sat", vector_c_s, e[VW-1:0]);
            check("rnd_flags_sat", sat_flags_s, e[VW+N-1:VW]);
         end
         if (exp_t_q.size() > 0) begin
            e = exp_t_q.pop_front();
            check("rnd_vec_trn", vector_c_t, e[VW-1:0]);
            check("rnd_flags_trn", sat_flags_t, e[VW+N-1:VW]);
         end
         if (i < 9) begin
            matrix_a = ra[i+1];
            vector_b = rb[i+1];
            in_valid = 1'b1;
         end
         release_out();
         check("rnd_valid_drop", out_valid_s, 0);
      end
      seen = 0;
      repeat (12) begin
         tick();
         if (out_valid_s || out_valid_t) seen++;
      end
      check("rnd_no_duplicate", seen, 0);
      check("rnd_queue_empty", exp_q.size() + exp_t_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
